// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port data memory for the RISC core.
// Self-initialises after reset (word 0 = RESET_VEC, word 1 = IRQ_VEC, rest 0,
// one word per cycle), then serves registered reads with a valid strobe and
// writes with protection of the low system-vector words. Word 1 is mirrored
// in a register so the interrupt controller sees it without a RAM port.
module data_memory_ctrl #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 8,
  parameter logic [DATA_W-1:0] RESET_VEC = '0,
  parameter logic [DATA_W-1:0] IRQ_VEC   = DATA_W'(8'h3C),
  parameter int                PROT_TOP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              vec_unlock,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              busy,
  output logic              wr_fault,
  output logic [DATA_W-1:0] interrupt_vector
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Init ends when the pointer sits on the last word, not when it wraps.
  localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROT_TOP);
  localparam logic [ADDR_W-1:0] IRQ_ADDR  = ADDR_W'(1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_fault_q, wr_fault_d;
  logic [DATA_W-1:0]   irq_vec_q, irq_vec_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   init_value;
  logic                write_blocked;

  // Value the init sequence stores at the current pointer.
  always_comb begin
    init_value = '0;
    if (init_ptr_q == '0) begin
      init_value = RESET_VEC;
    end else if (init_ptr_q == IRQ_ADDR) begin
      init_value = IRQ_VEC;
    end
  end

  assign write_blocked = (addr <= PROT_ADDR) && !vec_unlock;

  // Next-state, RAM write port selection and registered-output updates.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    wr_fault_d = 1'b0;
    irq_vec_d  = irq_vec_q;
    ram_we     = 1'b0;
    ram_waddr  = addr;
    ram_wdata  = data_in;

    unique case (state_q)
      ST_INIT: begin
        ram_we     = 1'b1;
        ram_waddr  = init_ptr_q;
        ram_wdata  = init_value;
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == LAST_PTR) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        if (mem_read) begin
          data_out_d = mem[addr];
          rd_valid_d = 1'b1;
        end
        if (mem_write) begin
          if (write_blocked) begin
            wr_fault_d = 1'b1;
          end else begin
            ram_we = 1'b1;
            if (addr == IRQ_ADDR) begin
              irq_vec_d = data_in;
            end
          end
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // RAM array: no reset. While rst is held the state sits in INIT at pointer
  // 0, so the only store possible is RESET_VEC into word 0, which init
  // rewrites anyway; user writes in flight when reset hits are dropped.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_waddr] <= ram_wdata;
    end
  end

  // Control and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      wr_fault_q <= 1'b0;
      irq_vec_q  <= IRQ_VEC;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      wr_fault_q <= wr_fault_d;
      irq_vec_q  <= irq_vec_d;
    end
  end

  assign data_out         = data_out_q;
  assign rd_valid         = rd_valid_q;
  assign busy             = (state_q == ST_INIT);
  assign wr_fault         = wr_fault_q;
  assign interrupt_vector = irq_vec_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed plus randomized bench for data_memory_ctrl
// at default parameters, with a behavioural model of the memory.
module tb_data_memory_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       vec_unlock;
  logic [7:0] data_out;
  logic       rd_valid;
  logic       busy;
  logic       wr_fault;
  logic [7:0] interrupt_vector;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  data_memory_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .addr             (addr),
    .data_in          (data_in),
    .vec_unlock       (vec_unlock),
    .data_out         (data_out),
    .rd_valid         (rd_valid),
    .busy             (busy),
    .wr_fault         (wr_fault),
    .interrupt_vector (interrupt_vector)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Hard stop in case something stalls the stimulus entirely.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  // Behavioural model: a plain array for the RAM, a counter of words left to
  // initialise, and the expected value of every registered output.
  logic [7:0] model_mem [256];
  int         init_cnt;
  logic       exp_busy;
  logic       exp_rd_valid;
  logic       exp_wr_fault;
  logic [7:0] exp_data_out;
  logic [7:0] exp_irq;

  // Model update: reset values on rst low, one init word per edge while
  // busy, then read-first reads and protection-aware writes.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_cnt     <= 0;
      exp_busy     <= 1'b1;
      exp_rd_valid <= 1'b0;
      exp_wr_fault <= 1'b0;
      exp_data_out <= 8'h00;
      exp_irq      <= 8'h3C;
    end else if (exp_busy) begin
      model_mem[init_cnt] <= (init_cnt == 1) ? 8'h3C : 8'h00;
      init_cnt     <= init_cnt + 1;
      exp_busy     <= (init_cnt + 1 < 256);
      exp_rd_valid <= 1'b0;
      exp_wr_fault <= 1'b0;
    end else begin
      exp_rd_valid <= mem_read;
      if (mem_read) exp_data_out <= model_mem[addr];
      exp_wr_fault <= mem_write && (addr <= 8'd1) && !vec_unlock;
      if (mem_write && !((addr <= 8'd1) && !vec_unlock)) begin
        model_mem[addr] <= data_in;
        if (addr == 8'd1) exp_irq <= data_in;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("busy", busy, exp_busy);
      checkOutput("rd_valid", rd_valid, exp_rd_valid);
      checkOutput("wr_fault", wr_fault, exp_wr_fault);
      checkOutput("data_out", data_out, exp_data_out);
      checkOutput("interrupt_vector", interrupt_vector, exp_irq);
    end
  end

  task automatic idleInputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    vec_unlock = 1'b0;
    addr       = 8'h00;
    data_in    = 8'h00;
  endtask

  // Called at a falling edge: drive one request for exactly one rising edge,
  // return at the next falling edge with inputs idle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] a,
                               input logic [7:0] d, input logic unl);
    mem_read   = rd;
    mem_write  = wr;
    addr       = a;
    data_in    = d;
    vec_unlock = unl;
    @(negedge clk);
    idleInputs();
  endtask

  task automatic readCheck(input logic [7:0] a, input logic [7:0] expected, input string name);
    applyStimulus(1'b1, 1'b0, a, 8'h00, 1'b0);
    checkOutput(name, data_out, expected);
    checkOutput({name, "_valid"}, rd_valid, 1'b1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_data_out"}, data_out, 8'h00);
    checkOutput({tag, "_rd_valid"}, rd_valid, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b1);
    checkOutput({tag, "_wr_fault"}, wr_fault, 1'b0);
    checkOutput({tag, "_irq"}, interrupt_vector, 8'h3C);
  endtask

  // Counts rising edges until busy drops, starting from a falling edge;
  // rd_valid must stay low throughout. Bounded at 400 edges.
  task automatic waitInit(input int start, output int edges);
    int n;
    n = start;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
      if (busy) checkOutput("init_rd_valid", rd_valid, 1'b0);
    end
    edges = n;
  endtask

  // Asserts reset just after a falling edge, holds it, checks reset values,
  // then releases on a falling edge.
  task automatic pulseReset(input int cycles, input string tag);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (cycles) @(negedge clk);
    checkResetValues(tag);
    rst = 1'b1;
  endtask

  initial begin
    int edges;
    rst = 1'b0;
    idleInputs();
    repeat (3) @(negedge clk);
    check_en = 1'b1;
    checkResetValues("por");
    rst = 1'b1;

    // Plain init: busy for 256 edges, then the vector words are in place.
    waitInit(0, edges);
    checkOutput("init_edges", edges, 256);
    readCheck(8'd0, 8'h00, "rd_word0");
    readCheck(8'd1, 8'h3C, "rd_word1");
    readCheck(8'd200, 8'h00, "rd_word200");
    checkOutput("irq_after_init", interrupt_vector, 8'h3C);

    // Write then read on the next edge; rd_valid is a single-cycle strobe.
    applyStimulus(1'b0, 1'b1, 8'h40, 8'hA5, 1'b0);
    readCheck(8'h40, 8'hA5, "wr_rd_40");
    @(negedge clk);
    checkOutput("rd_valid_drop", rd_valid, 1'b0);
    checkOutput("data_out_hold", data_out, 8'hA5);

    // Blocked write to word 1, then an unlocked one.
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h55, 1'b0);
    checkOutput("fault_pulse", wr_fault, 1'b1);
    checkOutput("irq_locked", interrupt_vector, 8'h3C);
    @(negedge clk);
    checkOutput("fault_clear", wr_fault, 1'b0);
    readCheck(8'd1, 8'h3C, "rd_word1_locked");
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h55, 1'b1);
    checkOutput("irq_unlocked", interrupt_vector, 8'h55);
    checkOutput("no_fault_unlocked", wr_fault, 1'b0);

    // Read and write to the same address on one edge return the old value.
    applyStimulus(1'b0, 1'b1, 8'h10, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h10, 8'h22, 1'b0);
    checkOutput("collision_old", data_out, 8'h11);
    readCheck(8'h10, 8'h22, "collision_new");

    // Reset mid-init, then requests while busy must be ignored.
    pulseReset(2, "rst1");
    repeat (100) @(negedge clk);
    pulseReset(3, "rst_mid");
    repeat (100) @(negedge clk);
    mem_read  = 1'b1;
    mem_write = 1'b1;
    addr      = 8'h05;
    data_in   = 8'h77;
    waitInit(100, edges);
    idleInputs();
    checkOutput("reinit_edges", edges, 256);
    readCheck(8'h05, 8'h00, "rd_05_after_init");
    readCheck(8'd1, 8'h3C, "rd_word1_reinit");

    // Randomized traffic, biased towards the protected words.
    for (int i = 0; i < 3000; i++) begin
      mem_read   = 1'($urandom_range(0, 1));
      mem_write  = 1'($urandom_range(0, 1));
      vec_unlock = ($urandom_range(0, 9) < 3);
      addr       = ($urandom_range(0, 9) < 3) ? 8'($urandom_range(0, 3))
                                              : 8'($urandom_range(0, 255));
      data_in    = 8'($urandom_range(0, 255));
      @(negedge clk);
    end
    idleInputs();
    @(negedge clk);

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
# data_memory_ctrl

Parametrised data memory for the RISC core, sitting between the execute/memory stage and the register-file write-back. It provides registered reads with a valid strobe, self-initialisation after reset (clear plus vector load, one word per cycle), write protection of the system-vector words, and a registered interrupt-vector output for the interrupt controller.

## Interface

**Parameters**
- `DATA_W`, default 8: word width in bits.
- `ADDR_W`, default 8: address width; depth is `DEPTH = 2**ADDR_W`.
- `RESET_VEC`, default 8'h00: value loaded into word 0 during init.
- `IRQ_VEC`, default 8'h3C: value loaded into word 1 during init.
- `PROT_TOP`, default 1: addresses 0..`PROT_TOP` are write-protected.

**Ports**
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-low reset. `rst`=0 resets immediately, regardless of `clk`.
- `mem_read` in 1: read request, sampled on a rising edge.
- `mem_write` in 1: write request, sampled on a rising edge.
- `addr` in `ADDR_W`: word address.
- `data_in` in `DATA_W`: write data.
- `vec_unlock` in 1: when 1, writes to the protected region are permitted.
- `data_out` out `DATA_W`: registered read data.
- `rd_valid` out 1: one-cycle strobe; `data_out` is valid while it is high.
- `busy` out 1: high during reset and init; requests are ignored while high.
- `wr_fault` out 1: one-cycle pulse after a blocked write to the protected region.
- `interrupt_vector` out `DATA_W`: registered shadow of word 1.

## Operation

**States.** There are two: `INIT` and `READY`.

**Reset (`rst`=0), asynchronous.**
- State goes to `INIT` and `init_ptr`=0.
- Outputs: `data_out`=0, `rd_valid`=0, `busy`=1, `wr_fault`=0, `interrupt_vector`=`IRQ_VEC`.
- RAM contents are not touched by reset itself.

**INIT.**
- Each cycle writes `RAM[init_ptr]` and then increments `init_ptr`. The value written is `RESET_VEC` at pointer 0, `IRQ_VEC` at pointer 1, and 0 elsewhere.
- When the write at `init_ptr`=`DEPTH-1` completes, the block moves to `READY` and `busy` drops on the same edge.
- `mem_read` and `mem_write` are ignored: no RAM change, no `rd_valid`, no `wr_fault`.

**READY, read.**
- `mem_read`=1 at edge N gives `data_out`=`RAM[addr]` and `rd_valid`=1 after edge N.
- `rd_valid` returns to 0 after the next edge unless another read is issued.
- `data_out` holds its last value when no read is issued.

**READY, write.**
- `mem_write`=1 commits `RAM[addr]`<=`data_in` at the edge, with one exception: a write with `addr`<=`PROT_TOP` and `vec_unlock`=0 is blocked. A blocked write leaves RAM unchanged and sets `wr_fault`=1 for exactly one cycle.
- A committed write to address 1 also updates `interrupt_vector`<=`data_in` on the same edge.

**Simultaneous read and write, same edge.**
- Both are performed.
- For the same address, the read is read-first: `data_out` returns the old contents.

**Address arithmetic.**
- `init_ptr` is `ADDR_W` bits wide; termination is detected at `DEPTH-1`, not by wrap.
- `addr` is used unmodified; there is no out-of-range case.

**Reset mid-INIT or mid-access.** Reset aborts the operation and init restarts from pointer 0. Any write in flight on that edge is lost.

## Timing

- Init latency is exactly `DEPTH` rising edges after `rst` deasserts; `busy` is low from the edge that writes `DEPTH-1`. This is 256 cycles at defaults.
- Read latency is 1 cycle, and back-to-back reads on consecutive cycles are supported. `rd_valid` stays high for consecutive reads.
- Writes take 1 cycle, and the written data is visible to a read issued on the following edge.
- `wr_fault` asserts 1 cycle after the blocked request.
- `interrupt_vector` changes on the same edge as the commit to word 1.
- Deassertion of `rst` is assumed synchronised upstream; the block contains no reset synchroniser.

## Test plan

- **Reset and init.** Pulse `rst` low, then release. Require `busy`=1 for 256 edges, then 0. Reads after init must give `RAM[0]`=00, `RAM[1]`=3C, `RAM[200]`=00, and `interrupt_vector`=3C throughout.
- **Write then read.** Write 0xA5 to address 0x40, then read 0x40 on the next cycle. Require `data_out`=A5 and `rd_valid`=1 exactly one cycle after the read edge.
- **Protected write.** Write 0x55 to address 1 with `vec_unlock`=0. Require a one-cycle `wr_fault` pulse, `interrupt_vector` still 3C, and a read of address 1 returning 3C. Repeat with `vec_unlock`=1: require `interrupt_vector`=55 on the write edge and no `wr_fault`.
- **Read-first collision.** With `RAM[0x10]`=11, issue read and write of 0x22 to 0x10 on the same edge. Require `data_out`=11; a following read returns 22.
- **Requests during init.** Issue a write of 0x77 to 0x05 and a read while `busy`=1. Require `rd_valid` to stay 0, and a read after init of 0x05 to return 00.
- **Reset mid-init.** Assert `rst` after 100 init cycles, then release. Require `busy` to be high for a full 256 further edges, with outputs at their reset values during reset.
